// File: rtl/dac_sample_streamer.sv
// -----------------------------------------------------------------------------
// dac_sample_streamer
//
// Streams DW-bit samples from an upstream register block into a parallel DAC.
// Samples are buffered in a DEPTH-word FIFO and emitted one per conversion
// period of P = rate_div + 2 aclk cycles. Each period with data:
//   - the period-start edge (cnt==0, enable=1) pops the head word onto
//     dac_data and drives dac_clk low,
//   - dac_clk rises on the edge leaving cnt==P/2, so dac_data has P/2 cycles
//     of setup to the DAC's latching edge,
//   - dac_clk then stays high until the next period-start edge.
// A period that starts with an empty FIFO keeps dac_clk low, holds dac_data
// and sets the sticky underrun flag.
//
// Ports
//   aclk        in   single clock for all logic
//   aresetn     in   asynchronous active-low reset
//   s_valid     in   upstream sample valid
//   s_ready     out  FIFO can accept a sample (!full && !flush, combinational)
//   s_data      in   [DW-1:0] sample word
//   enable      in   conversions run while high
//   flush       in   one-cycle pulse: empty FIFO, clear underrun
//   rate_div    in   [15:0] conversion period P = rate_div + 2
//   dac_clk     out  DAC latch clock (DAC samples on rising edge)
//   dac_data    out  [DW-1:0] registered DAC data bus
//   fifo_level  out  [$clog2(DEPTH):0] words currently stored
//   underrun    out  sticky: a period started with an empty FIFO
// -----------------------------------------------------------------------------
module dac_sample_streamer #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [15:0]            rate_div,
    output logic                   dac_clk,
    output logic [DW-1:0]          dac_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underrun
);

    localparam int AW = $clog2(DEPTH);
    // Period can reach 0xFFFF + 2, so one bit wider than rate_div.
    localparam int PW = 17;

    // Phase of the current conversion period.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // enable low, counter parked at 0
        ST_PLAY   = 2'd1,   // a word was popped at this period's start
        ST_STARVE = 2'd2    // period started with an empty FIFO
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_rd_ptr_nxt;

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] r_period;
    logic [PW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_period_cur;
    logic [PW-1:0] w_half;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_dac_clk;
    logic          w_dac_clk_nxt;
    logic [DW-1:0] r_dac_data;
    logic          r_underrun;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_start;
    logic          w_pop;
    logic          w_cnt_last;
    logic [DW-1:0] w_head;

    // -------------------------------------------------------------------------
    // FIFO status and handshake
    // -------------------------------------------------------------------------
    // r_level is registered from the next-state pointers, so it is exact every
    // cycle and can stand in for the pointer comparison.
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);

    // Gating with aresetn keeps s_ready low throughout reset and lets it rise
    // on the very first cycle after release.
    assign s_ready = aresetn && !w_full && !flush;
    assign w_push  = s_valid && s_ready;

    // Period start is judged on the registered counter; a word pushed into an
    // empty FIFO is only visible through r_level one edge later, so there is
    // no bypass path from s_data to dac_data.
    assign w_start = enable && (r_cnt == '0);
    assign w_pop   = w_start && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Flush wins over push and pop: both pointers return to zero. A pop on the
    // same edge still presents the head word on dac_data.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
        end
    end

    // NOTE: the sample storage is deliberately not reset; the pointers define
    // which entries are valid, and leaving the array out of reset lets it map
    // onto plain RAM.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_data;
        end
    end

    // -------------------------------------------------------------------------
    // Period counter
    // -------------------------------------------------------------------------
    // At cnt==0 the period being started takes the live rate_div; elsewhere the
    // period latched at the last start applies, so mid-period changes wait.
    assign w_period_cur = (r_cnt == '0) ? ({1'b0, rate_div} + PW'(2)) : r_period;
    assign w_half       = w_period_cur >> 1;
    assign w_cnt_last   = (r_cnt == (w_period_cur - PW'(1)));

    always_comb begin
        w_cnt_nxt = r_cnt + PW'(1);
        if (!enable || w_cnt_last) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt    <= '0;
            r_period <= PW'(2);
        end else begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == '0) begin
                r_period <= w_period_cur;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Conversion phase FSM and DAC outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dac_clk_nxt = r_dac_clk;
        if (!enable) begin
            // Disabling aborts the period outright; a popped word is not
            // replayed when enable returns.
            w_state_nxt   = ST_IDLE;
            w_dac_clk_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = w_empty ? ST_STARVE : ST_PLAY;
            w_dac_clk_nxt = 1'b0;
        end else if ((r_state == ST_PLAY) && (r_cnt == w_half)) begin
            // cnt >= 1 here because P/2 >= 1. For P=2 this is the last cycle
            // of the period, giving one low and one high cycle per sample.
            w_dac_clk_nxt = 1'b1;
        end
    end

    // Reset drives dac_clk low asynchronously, so a reset during a conversion
    // cannot produce a spurious rising edge at the DAC.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dac_clk  <= 1'b0;
            r_dac_data <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_dac_clk <= w_dac_clk_nxt;
            if (w_pop) begin
                r_dac_data <= w_head;
            end
            if (flush) begin
                r_underrun <= 1'b0;
            end else if (w_start && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign dac_clk    = r_dac_clk;
    assign dac_data   = r_dac_data;
    assign fifo_level = r_level;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_dac_sample_streamer.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_streamer
//
// Directed bench for dac_sample_streamer. Inputs are driven and outputs are
// sampled on the falling edge of aclk; expected values are hand-derived from
// the cycle timeline (period start on the edge leaving cnt==0, dac_clk high
// from the edge leaving cnt==P/2 until the next period start).
// -----------------------------------------------------------------------------
module tb_dac_sample_streamer;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          aclk     = 1'b0;
    logic          aresetn  = 1'b0;
    logic          s_valid  = 1'b0;
    logic [DW-1:0] s_data   = '0;
    logic          enable   = 1'b0;
    logic          flush    = 1'b0;
    logic [15:0]   rate_div = '0;
    logic          s_ready;
    logic          dac_clk;
    logic [DW-1:0] dac_data;
    logic [4:0]    fifo_level;
    logic          underrun;

    int errors = 0;
    int checks = 0;

    // Words seen by the DAC on each rising edge of dac_clk.
    logic [DW-1:0] cap_q [$];

    dac_sample_streamer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .enable     (enable),
        .flush      (flush),
        .rate_div   (rate_div),
        .dac_clk    (dac_clk),
        .dac_data   (dac_data),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    always #5 aclk = ~aclk;

    always @(posedge dac_clk) cap_q.push_back(dac_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] a_data [8];
        logic       a_clk  [8];
        logic       a_und  [8];
        logic [4:0] a_lvl  [8];
        logic       rdy;
        logic       exp_clk;
        logic [7:0] exp_dat;
        int         idx;

        a_data = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
        a_clk  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        a_und  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        a_lvl  = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_dac_clk",  32'(dac_clk),    32'd0);
        check("rst_dac_data", 32'(dac_data),   32'd0);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_underrun", 32'(underrun),   32'd0);
        check("rst_s_ready",  32'(s_ready),    32'd0);
        aresetn = 1'b1;
        tick();
        check("rdy_after_rst", 32'(s_ready), 32'd1);

        // ---------------- P=2, three words then underrun ----------------
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("a_level3", 32'(fifo_level), 32'd3);
        rate_div = 16'd0;
        enable   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("a_clk_%0d", c),  32'(dac_clk),    32'(a_clk[c]));
            check($sformatf("a_data_%0d", c), 32'(dac_data),   32'(a_data[c]));
            check($sformatf("a_und_%0d", c),  32'(underrun),   32'(a_und[c]));
            check($sformatf("a_lvl_%0d", c),  32'(fifo_level), 32'(a_lvl[c]));
        end
        enable = 1'b0;
        tick();

        // ---------------- flush with simultaneous push ----------------
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'hA5);
        check("b_level5", 32'(fifo_level), 32'd5);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        flush   = 1'b1;
        #1;
        check("b_ready_flush", 32'(s_ready), 32'd0);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        check("b_level0",   32'(fifo_level), 32'd0);
        check("b_und_clr",  32'(underrun),   32'd0);
        push(8'h5A);
        check("b_level1", 32'(fifo_level), 32'd1);
        enable = 1'b1;
        tick();
        check("b_data",  32'(dac_data), 32'h5A);
        check("b_clk_lo", 32'(dac_clk), 32'd0);
        tick();
        check("b_clk_hi", 32'(dac_clk), 32'd1);
        enable = 1'b0;
        tick();
        check("b_clk_off", 32'(dac_clk),  32'd0);
        check("b_und_off", 32'(underrun), 32'd0);

        // ---------------- P=10, 20 words with back-pressure ----------------
        cap_q.delete();
        rate_div = 16'd8;
        s_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(8'h40 + i);
            tick();
        end
        s_data = 8'h50;
        check("c_level16", 32'(fifo_level), 32'd16);
        check("c_full_rdy", 32'(s_ready),   32'd0);
        idx    = 16;
        enable = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            rdy = s_ready;
            tick();
            if (rdy && s_valid) begin
                idx++;
                if (idx < 20) s_data = 8'(8'h40 + idx);
                else          s_valid = 1'b0;
            end
            exp_clk = ((c % 10) == 0) ? 1'b1 : ((c % 10) >= 6);
            check($sformatf("c_clk_%0d", c), 32'(dac_clk), 32'(exp_clk));
            if (c == 1) check("c_level15", 32'(fifo_level), 32'd15);
            if (c == 2) begin
                check("c_refill16", 32'(fifo_level), 32'd16);
                check("c_refull_rdy", 32'(s_ready),  32'd0);
            end
        end
        check("c_level_end", 32'(fifo_level), 32'd0);
        enable = 1'b0;
        tick();
        check("c_clk_off", 32'(dac_clk),  32'd0);
        check("c_und",     32'(underrun), 32'd0);
        check("c_count",   32'(cap_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < cap_q.size()) check($sformatf("c_order_%0d", i), 32'(cap_q[i]), 32'(8'h40 + i));
        end

        // ---------------- rate change mid-period ----------------
        push(8'h71);
        push(8'h72);
        push(8'h73);
        enable = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_dat = (c <= 10) ? 8'h71 : ((c <= 14) ? 8'h72 : 8'h73);
            exp_clk = ((c >= 6) && (c <= 10)) || (c == 13) || (c == 14);
            check($sformatf("d_data_%0d", c), 32'(dac_data), 32'(exp_dat));
            check($sformatf("d_clk_%0d", c),  32'(dac_clk),  32'(exp_clk));
            if (c == 3) rate_div = 16'd2;
        end
        enable = 1'b0;
        tick();
        rate_div = 16'd8;

        // ---------------- enable dropped at cnt=7 ----------------
        push(8'h81);
        push(8'h82);
        enable = 1'b1;
        repeat (7) tick();
        check("e_clk_pre",  32'(dac_clk),    32'd1);
        check("e_data_pre", 32'(dac_data),   32'h81);
        enable = 1'b0;
        tick();
        check("e_clk_abort", 32'(dac_clk),    32'd0);
        check("e_data_hold", 32'(dac_data),   32'h81);
        check("e_level",     32'(fifo_level), 32'd1);
        tick();
        enable = 1'b1;
        tick();
        check("e_next_word", 32'(dac_data),   32'h82);
        check("e_level0",    32'(fifo_level), 32'd0);
        enable = 1'b0;
        tick();

        // ---------------- reset mid-period ----------------
        push(8'h91);
        push(8'h92);
        push(8'h93);
        enable = 1'b1;
        repeat (6) tick();
        check("f_clk_pre", 32'(dac_clk),    32'd1);
        check("f_lvl_pre", 32'(fifo_level), 32'd2);
        aresetn = 1'b0;
        #1;
        check("f_clk_rst",  32'(dac_clk),    32'd0);
        check("f_data_rst", 32'(dac_data),   32'd0);
        check("f_lvl_rst",  32'(fifo_level), 32'd0);
        check("f_und_rst",  32'(underrun),   32'd0);
        check("f_rdy_rst",  32'(s_ready),    32'd0);
        enable = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("f_rdy_rel", 32'(s_ready),    32'd1);
        check("f_lvl_rel", 32'(fifo_level), 32'd0);
        rate_div = 16'd0;
        push(8'hA7);
        enable = 1'b1;
        tick();
        check("f_fresh_word", 32'(dac_data),   32'hA7);
        check("f_fresh_lvl",  32'(fifo_level), 32'd0);
        enable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
